ula_sequencial: RTL and testbench

- Parametrised, registered ALU for the RISC-V datapath.
- Picks two operands from {dina, dinb, constante, 0} through independent selectors.
- Executes add/sub, logic, compare and shift ops in one cycle, and multiply over BITS cycles with an iterative shift-add.
- Uses a valid/ready handshake so the control unit can stall on multi-cycle ops.

---
 rtl/ula_sequencial.sv | 192 +++++++++++++++++++
 tb/tb_ula_sequencial.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencial.sv
// ula_sequencial: registered ALU for the RISC-V datapath.
// Single-cycle add/sub/logic/compare/shift, plus an optional iterative
// shift-add multiplier that takes exactly BITS cycles. A valid/ready
// handshake (valid_in / pronto) lets the control unit stall on MUL.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; single-cycle ops complete here
// MULT  | shift-add multiply in progress, one partial product per cycle
module ula_sequencial #(
  parameter int BITS       = 64,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [BITS-1:0] dina,
  input  logic [BITS-1:0] dinb,
  input  logic [BITS-1:0] constante,
  input  logic [1:0]      escolhe_entrada1,
  input  logic [1:0]      escolhe_entrada2,
  input  logic [3:0]      operacao,
  input  logic            valid_in,
  output logic            pronto,
  output logic [BITS-1:0] dout,
  output logic            zero,
  output logic            erro,
  output logic            valid_out
);

  localparam int SHW = $clog2(BITS);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(BITS - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] dout_q, dout_d;
  logic            zero_q, zero_d;
  logic            erro_q, erro_d;
  logic            valid_out_q, valid_out_d;
  logic [BITS-1:0] mcand_q, mcand_d;
  logic [BITS-1:0] mplier_q, mplier_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic [BITS-1:0] fator1, fator2;
  logic [BITS-1:0] alu_res;
  logic            alu_illegal;
  logic [SHW-1:0]  shamt;
  logic [BITS-1:0] acc_next;
  logic            accept;
  logic            is_mul;

  // Operand 1 select; selector 11 yields zero so an immediate can be moved as 0 + constante.
  always_comb begin
    case (escolhe_entrada1)
      2'b00:   fator1 = dina;
      2'b01:   fator1 = dinb;
      2'b10:   fator1 = constante;
      default: fator1 = '0;
    endcase
  end

  // Operand 2 select, same encoding as operand 1.
  always_comb begin
    case (escolhe_entrada2)
      2'b00:   fator2 = dina;
      2'b01:   fator2 = dinb;
      2'b10:   fator2 = constante;
      default: fator2 = '0;
    endcase
  end

  assign accept = valid_in && (state_q == IDLE);
  assign is_mul = MUL_ENABLE && (operacao == OP_MUL);

  // Single-cycle datapath; anything not decoded here (including MUL) is flagged illegal.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    shamt       = fator2[SHW-1:0];
    case (operacao)
      OP_ADD:  alu_res = fator1 + fator2;
      OP_SUB:  alu_res = fator1 - fator2;
      OP_AND:  alu_res = fator1 & fator2;
      OP_OR:   alu_res = fator1 | fator2;
      OP_XOR:  alu_res = fator1 ^ fator2;
      OP_SLT:  alu_res = {{(BITS-1){1'b0}}, ($signed(fator1) < $signed(fator2))};
      OP_SLTU: alu_res = {{(BITS-1){1'b0}}, (fator1 < fator2)};
      OP_SLL:  alu_res = fator1 << shamt;
      OP_SRL:  alu_res = fator1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(fator1) >>> shamt);
      default: alu_illegal = 1'b1;
    endcase
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and result logic; results only change on an accepting edge or the last MUL step.
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    zero_d      = zero_q;
    erro_d      = erro_q;
    valid_out_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mcand_d  = fator1;
            mplier_d = fator2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MULT;
          end else begin
            dout_d      = alu_illegal ? '0 : alu_res;
            zero_d      = alu_illegal ? 1'b1 : (alu_res == '0);
            erro_d      = alu_illegal;
            valid_out_d = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Fixed latency: no early exit even when the multiplier runs out of ones.
        if (cnt_q == CNT_LAST) begin
          dout_d      = acc_next;
          zero_d      = (acc_next == '0);
          erro_d      = 1'b0;
          valid_out_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any multiply without a strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      zero_q      <= 1'b0;
      erro_q      <= 1'b0;
      valid_out_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      zero_q      <= zero_d;
      erro_q      <= erro_d;
      valid_out_q <= valid_out_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pronto    = (state_q == IDLE);
  assign dout      = dout_q;
  assign zero      = zero_q;
  assign erro      = erro_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Bench for ula_sequencial: a 64-bit instance with the multiplier and an
// 8-bit instance without it share one stimulus stream. Expected results come
// from a plain-arithmetic reference model and are queued per instance; monitors
// pop and compare (value and arrival cycle) whenever a result strobe appears.
module tb_ula_sequencial;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] dina, dinb, constante;
  logic [1:0]  sel1, sel2;
  logic [3:0]  operacao;
  logic        valid_in;

  logic        pronto64, zero64, erro64, vo64;
  logic [63:0] dout64;
  logic        pronto8, zero8, erro8, vo8;
  logic [7:0]  dout8;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [63:0] dout;
    logic        erro;
    int          cyc;
  } exp_t;

  exp_t q64[$];
  exp_t q8[$];

  ula_sequencial #(.BITS(64), .MUL_ENABLE(1'b1)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .dina(dina), .dinb(dinb), .constante(constante),
    .escolhe_entrada1(sel1), .escolhe_entrada2(sel2),
    .operacao(operacao), .valid_in(valid_in),
    .pronto(pronto64), .dout(dout64), .zero(zero64), .erro(erro64), .valid_out(vo64)
  );

  ula_sequencial #(.BITS(8), .MUL_ENABLE(1'b0)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .dina(dina[7:0]), .dinb(dinb[7:0]), .constante(constante[7:0]),
    .escolhe_entrada1(sel1), .escolhe_entrada2(sel2),
    .operacao(operacao), .valid_in(valid_in),
    .pronto(pronto8), .dout(dout8), .zero(zero8), .erro(erro8), .valid_out(vo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] pick(input logic [1:0] s, input logic [63:0] a, b, c);
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return 64'd0;
    endcase
  endfunction

  // Reference ALU of width w (8..64): operands and result are masked to w bits.
  function automatic exp_t model(input int w, input bit mul_en, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t        e;
    logic [63:0] m, a, b, r;
    longint      sa, sb;
    int          sh;
    bit          bad;
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a   = a_in & m;
    b   = b_in & m;
    sa  = longint'(a << (64 - w)) >>> (64 - w);
    sb  = longint'(b << (64 - w)) >>> (64 - w);
    sh  = int'(b & 64'(w - 1));
    bad = 1'b0;
    r   = 64'd0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd6:  r = (a < b) ? 64'd1 : 64'd0;
      4'd7:  r = a << sh;
      4'd8:  r = a >> sh;
      4'd9:  r = 64'(sa >>> sh);
      4'd10: if (mul_en) r = a * b; else bad = 1'b1;
      default: bad = 1'b1;
    endcase
    e.dout = bad ? 64'd0 : (r & m);
    e.erro = bad;
    e.cyc  = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(15));
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {1'b1, 31'($urandom), $urandom};
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [1:0] s1, s2, input logic [63:0] a, b, c);
    operacao  = op;
    sel1      = s1;
    sel2      = s2;
    dina      = a;
    dinb      = b;
    constante = c;
    valid_in  = 1'b1;
  endtask

  // Queue expectations for a request that will be accepted on the coming edge.
  task automatic push_exp(input logic [3:0] op, input logic [1:0] s1, s2,
                          input logic [63:0] a, b, c, input bit to64, input int lat64);
    exp_t        e;
    logic [63:0] f1, f2;
    f1 = pick(s1, a, b, c);
    f2 = pick(s2, a, b, c);
    if (to64) begin
      e     = model(64, 1'b1, op, f1, f2);
      e.cyc = cyc + 1 + lat64;
      q64.push_back(e);
    end
    e     = model(8, 1'b0, op, f1, f2);
    e.cyc = cyc + 1;
    q8.push_back(e);
  endtask

  // Issue one request at a negedge; for MUL, stay through the stall, poking valid_in
  // at random (only the 8-bit instance accepts those). abort_at >= 0 resets mid-multiply.
  task automatic issue(input logic [3:0] op, input logic [1:0] s1, s2,
                       input logic [63:0] a, b, c, input int abort_at);
    exp_t       e;
    logic [3:0] rop;
    logic [1:0] rs1, rs2;
    chk("pronto64_ready", {63'd0, pronto64}, 64'd1);
    chk("pronto8_ready", {63'd0, pronto8}, 64'd1);
    drive(op, s1, s2, a, b, c);
    push_exp(op, s1, s2, a, b, c, 1'b1, (op == 4'd10) ? 64 : 0);
    @(negedge clk);
    valid_in = 1'b0;
    if (op == 4'd10) begin
      for (int j = 0; j < 64; j++) begin
        chk("pronto64_busy", {63'd0, pronto64}, 64'd0);
        chk("pronto8_free", {63'd0, pronto8}, 64'd1);
        if (j == abort_at) begin
          reset_n  = 1'b0;
          valid_in = 1'b0;
          e = q64.pop_back();
          @(negedge clk);
          reset_n = 1'b1;
          chk("abort_pronto", {63'd0, pronto64}, 64'd1);
          chk("abort_dout", dout64, 64'd0);
          chk("abort_zero", {63'd0, zero64}, 64'd0);
          chk("abort_erro", {63'd0, erro64}, 64'd0);
          chk("abort_strobe", {63'd0, vo64}, 64'd0);
          return;
        end
        rop = 4'($urandom_range(15));
        rs1 = 2'($urandom_range(3));
        rs2 = 2'($urandom_range(3));
        drive(rop, rs1, rs2, rnd64(), rnd64(), rnd64());
        if ($urandom_range(1) == 1) push_exp(rop, rs1, rs2, dina, dinb, constante, 1'b0, 0);
        else valid_in = 1'b0;
        @(negedge clk);
      end
      valid_in = 1'b0;
    end
  endtask

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (vo64 === 1'b1) begin
      if (q64.size() == 0) chk("strobe64_unexpected", {63'd0, vo64}, 64'd0);
      else begin
        e = q64.pop_front();
        chk("lat64", 64'(cyc), 64'(e.cyc));
        chk("dout64", dout64, e.dout);
        chk("zero64", {63'd0, zero64}, {63'd0, (e.dout == 64'd0)});
        chk("erro64", {63'd0, erro64}, {63'd0, e.erro});
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (vo8 === 1'b1) begin
      if (q8.size() == 0) chk("strobe8_unexpected", {63'd0, vo8}, 64'd0);
      else begin
        e = q8.pop_front();
        chk("lat8", 64'(cyc), 64'(e.cyc));
        chk("dout8", {56'd0, dout8}, e.dout);
        chk("zero8", {63'd0, zero8}, {63'd0, (e.dout == 64'd0)});
        chk("erro8", {63'd0, erro8}, {63'd0, e.erro});
      end
    end
  end

  initial begin
    logic [3:0] op;
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    operacao  = 4'd0;
    sel1      = 2'b00;
    sel2      = 2'b00;
    dina      = 64'd0;
    dinb      = 64'd0;
    constante = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_pronto64", {63'd0, pronto64}, 64'd1);
    chk("rst_dout64", dout64, 64'd0);
    chk("rst_zero64", {63'd0, zero64}, 64'd0);
    chk("rst_erro64", {63'd0, erro64}, 64'd0);
    chk("rst_vo64", {63'd0, vo64}, 64'd0);
    chk("rst_dout8", {56'd0, dout8}, 64'd0);
    chk("rst_vo8", {63'd0, vo8}, 64'd0);
    reset_n = 1'b1;

    issue(4'd0, 2'b00, 2'b10, 64'd5, 64'd0, 64'd7, -1);
    @(negedge clk);
    issue(4'd1, 2'b00, 2'b01, 64'd3, 64'd5, 64'd0, -1);
    issue(4'd4, 2'b00, 2'b01, 64'hFF, 64'h0F, 64'd0, -1);
    issue(4'd5, 2'b00, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, -1);
    issue(4'd6, 2'b00, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, -1);
    issue(4'd9, 2'b00, 2'b01, 64'h8000_0000_0000_0000, 64'd68, 64'd0, -1);
    issue(4'd0, 2'b11, 2'b10, 64'd9, 64'd9, 64'h1234, -1);
    issue(4'd10, 2'b00, 2'b01, 64'h1_0000_0001, 64'd3, 64'd0, -1);
    issue(4'd0, 2'b00, 2'b01, 64'd40, 64'd2, 64'd0, -1);
    repeat (2) @(negedge clk);
    issue(4'd10, 2'b00, 2'b01, 64'h1234_5678, 64'd77, 64'd0, 19);
    issue(4'd13, 2'b00, 2'b01, 64'd1, 64'd2, 64'd3, -1);
    issue(4'd0, 2'b00, 2'b01, 64'hFF, 64'd1, 64'd0, -1);
    issue(4'd10, 2'b00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, -1);

    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(15));
      issue(op, 2'($urandom_range(3)), 2'($urandom_range(3)), rnd64(), rnd64(), rnd64(), -1);
      if ($urandom_range(3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("drain64", 64'(q64.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
